// File: rtl/hp_bar_ctrl_pkg.sv
// Shared widths, colours and FSM state encoding for the HP-bar controller.
package hp_pkg;

  localparam int unsigned X_W  = 9;
  localparam int unsigned Y_W  = 8;
  localparam int unsigned HP_W = 9;

  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_GREEN = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DRAW = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/hp_bar_ctrl_if.sv
// Request/pixel-stream bundle between a battle sequencer and one HP-bar controller.
interface hp_bar_ctrl_if;
  import hp_pkg::*;

  logic              start;
  logic              heal;
  logic [HP_W-1:0]   amount;
  logic              plot;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic [2:0]        out_colour;
  logic              busy;
  logic              done;
  logic [HP_W-1:0]   hp;
  logic              game_over;

  modport master (
    output start, heal, amount,
    input  plot, out_x, out_y, out_colour, busy, done, hp, game_over
  );

  modport slave (
    input  start, heal, amount,
    output plot, out_x, out_y, out_colour, busy, done, hp, game_over
  );

endinterface

// File: rtl/hp_bar_scan.sv
// Column/row walker: visits every row of each column from first_x to last_x, one pixel per cycle.
module hp_bar_scan
  import hp_pkg::*;
#(
  parameter logic [Y_W-1:0] ROW0 = 8'd119,
  parameter int unsigned    ROWS = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic [X_W-1:0] first_x,
  input  logic [X_W-1:0] last_x,
  input  logic           down,
  output logic           valid,
  output logic [X_W-1:0] column,
  output logic [Y_W-1:0] row,
  output logic           last_c
);

  localparam logic [Y_W-1:0] ROW_END = Y_W'(32'(ROW0) + ROWS - 1);

  logic [X_W-1:0] end_x;
  logic           down_q;

  // Final pixel of the span is the bottom row of the end column.
  assign last_c = valid && (column == end_x) && (row == ROW_END);

  // Position counters; column/row hold their last value once the span is done.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= 1'b0;
      column <= '0;
      row    <= '0;
      end_x  <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      column <= first_x;
      row    <= ROW0;
      end_x  <= last_x;
      down_q <= down;
    end else if (valid) begin
      if (last_c) begin
        valid <= 1'b0;
      end else if (row == ROW_END) begin
        row    <= ROW0;
        column <= down_q ? column - X_W'(1) : column + X_W'(1);
      end else begin
        row <= row + Y_W'(1);
      end
    end
  end

endmodule

// File: rtl/hp_bar_ctrl.sv
// HP register with saturating damage/heal and an incremental bar redraw of the changed span.
module hp_bar_ctrl
  import hp_pkg::*;
#(
  parameter int unsigned    HP_MAX    = 48,
  parameter int unsigned    PX_PER_HP = 2,
  parameter logic [X_W-1:0] BAR_X     = 9'd200,
  parameter logic [Y_W-1:0] BAR_Y     = 8'd119,
  parameter int unsigned    BAR_H     = 3
) (
  input  logic       clock,
  input  logic       reset,
  hp_bar_ctrl_if.slave bus
);

  localparam logic [HP_W-1:0] HP_FULL = HP_W'(HP_MAX);

  if (HP_MAX < 1 || HP_MAX > 511) begin : g_bad_hp_max
    $error("hp_bar_ctrl: HP_MAX must be 1..511");
  end
  if (PX_PER_HP < 1 || HP_MAX * PX_PER_HP > 320 - 32'(BAR_X)) begin : g_bad_width
    $error("hp_bar_ctrl: bar does not fit on screen");
  end
  if (BAR_H < 1 || 32'(BAR_Y) + BAR_H > 240) begin : g_bad_height
    $error("hp_bar_ctrl: bar height out of range");
  end

  state_t          state, next_state;
  logic            busy_d, done_d, scan_load;
  logic            busy_q, done_q, game_over_q, heal_q;
  logic [HP_W-1:0] hp_q, amount_q;
  logic [2:0]      colour_q;

  logic [HP_W:0]   heal_sum;
  logic [HP_W-1:0] new_hp, lo_hp, hi_hp;
  logic [X_W-1:0]  x_lo, x_hi, first_x, last_x;

  logic            scan_valid, scan_last;
  logic [X_W-1:0]  scan_col;
  logic [Y_W-1:0]  scan_row;

  // Saturating HP update and the pixel span it uncovers.
  always_comb begin
    heal_sum = {1'b0, hp_q} + {1'b0, amount_q};
    new_hp   = hp_q;
    if (heal_q) begin
      if (game_over_q)                   new_hp = hp_q;
      else if (heal_sum > {1'b0, HP_FULL}) new_hp = HP_FULL;
      else                               new_hp = heal_sum[HP_W-1:0];
    end else begin
      new_hp = (amount_q >= hp_q) ? '0 : hp_q - amount_q;
    end
    lo_hp   = heal_q ? hp_q : new_hp;
    hi_hp   = heal_q ? new_hp : hp_q;
    x_lo    = BAR_X + X_W'(32'(lo_hp) * PX_PER_HP);
    x_hi    = BAR_X + X_W'(32'(hi_hp) * PX_PER_HP - 1);
    first_x = heal_q ? x_lo : x_hi;
    last_x  = heal_q ? x_hi : x_lo;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; busy/done are derived from the state being entered so they register cleanly.
  always_comb begin
    next_state = state;
    scan_load  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      S_IDLE: if (bus.start) next_state = S_CALC;
      S_CALC: begin
        if (new_hp == hp_q) begin
          next_state = S_FIN;
        end else begin
          next_state = S_DRAW;
          scan_load  = 1'b1;
        end
      end
      S_DRAW: if (scan_last) next_state = S_FIN;
      S_FIN:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    busy_d = (next_state == S_CALC) || (next_state == S_DRAW);
    done_d = (next_state == S_FIN);
  end

  // Request latch, HP register, sticky game-over and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      hp_q        <= HP_FULL;
      game_over_q <= 1'b0;
      heal_q      <= 1'b0;
      amount_q    <= '0;
      colour_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (state == S_IDLE && bus.start) begin
        heal_q   <= bus.heal;
        amount_q <= bus.amount;
      end
      if (state == S_CALC) begin
        hp_q     <= new_hp;
        colour_q <= heal_q ? COL_GREEN : COL_WHITE;
        if (new_hp == '0) game_over_q <= 1'b1;
      end
    end
  end

  hp_bar_scan #(
    .ROW0 (BAR_Y),
    .ROWS (BAR_H)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .load    (scan_load),
    .first_x (first_x),
    .last_x  (last_x),
    .down    (!heal_q),
    .valid   (scan_valid),
    .column  (scan_col),
    .row     (scan_row),
    .last_c  (scan_last)
  );

  assign bus.plot       = scan_valid;
  assign bus.out_x      = scan_col;
  assign bus.out_y      = scan_row;
  assign bus.out_colour = colour_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hp         = hp_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_hp_bar_ctrl.sv
// Scoreboard bench for hp_bar_ctrl with default parameters.
module tb_hp_bar_ctrl;
  import hp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hp_m = 48;

  logic [19:0] pix_q[$];
  int          done_q[$];
  logic [19:0] mon_e;
  int          mon_d;

  hp_bar_ctrl_if bus();

  hp_bar_ctrl #(
    .HP_MAX    (48),
    .PX_PER_HP (2),
    .BAR_X     (9'd200),
    .BAR_Y     (8'd119),
    .BAR_H     (3)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected pixels on plot and expected completion cycles on done.
  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      if (pix_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got pixel (%0d,%0d), expected none (cycle %0d)",
                 bus.out_x, bus.out_y, cyc);
      end else begin
        mon_e = pix_q.pop_front();
        chk("pix_x", int'(bus.out_x), int'(mon_e[19:11]));
        chk("pix_y", int'(bus.out_y), int'(mon_e[10:3]));
        chk("pix_colour", int'(bus.out_colour), int'(mon_e[2:0]));
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_d = done_q.pop_front();
        chk("done_cycle", cyc, mon_d);
        chk("done_busy_overlap", int'(bus.busy), 0);
      end
    end
  end

  // Issue one request; expected hp is hand-computed, pixel list comes from the bar model.
  task automatic issue(input logic h, input logic [8:0] amt, input int exp_hp,
                       input int exp_go, input int poke, input int rst_at);
    int t, n, lo, hi, guard;
    logic [2:0] col;
    lo  = h ? hp_m : exp_hp;
    hi  = h ? exp_hp : hp_m;
    n   = (hi - lo) * 2 * 3;
    col = h ? 3'b010 : 3'b111;
    if (h) begin
      for (int c = lo * 2; c < hi * 2; c++)
        for (int r = 0; r < 3; r++)
          pix_q.push_back({9'(200 + c), 8'(119 + r), col});
    end else begin
      for (int c = hi * 2 - 1; c >= lo * 2; c--)
        for (int r = 0; r < 3; r++)
          pix_q.push_back({9'(200 + c), 8'(119 + r), col});
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.heal   = h;
    bus.amount = amt;
    t = cyc;
    if (rst_at == 0) done_q.push_back(t + 2 + n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_in_calc", int'(bus.busy), 1);
    @(negedge clk);
    chk("hp_at_t2", int'(bus.hp), exp_hp);
    chk("game_over_at_t2", int'(bus.game_over), exp_go);
    hp_m = exp_hp;
    if (rst_at > 0) begin
      while (cyc < t + rst_at) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_plot", int'(bus.plot), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_hp", int'(bus.hp), 48);
      rst = 1'b0;
      pix_q.delete();
      done_q.delete();
      hp_m = 48;
      repeat (4) @(negedge clk);
      return;
    end
    if (poke > 0) begin
      while (cyc < t + poke) @(negedge clk);
      bus.start  = 1'b1;
      bus.heal   = 1'b1;
      bus.amount = 9'd5;
      @(negedge clk);
      bus.start = 1'b0;
    end
    guard = 0;
    while ((pix_q.size() != 0 || done_q.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: got %0d pixels and %0d done pulses outstanding, expected 0",
               pix_q.size(), done_q.size());
      pix_q.delete();
      done_q.delete();
    end
    @(negedge clk);
    chk("hp_after", int'(bus.hp), exp_hp);
    chk("game_over_after", int'(bus.game_over), exp_go);
    chk("busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.heal   = 1'b0;
    bus.amount = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hp", int'(bus.hp), 48);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_game_over", int'(bus.game_over), 0);
    chk("rst_out_x", int'(bus.out_x), 0);
    chk("rst_out_y", int'(bus.out_y), 0);
    chk("rst_colour", int'(bus.out_colour), 0);

    issue(1'b0, 9'd12,  36, 0, 0,  0);   // damage 12 from 48
    issue(1'b1, 9'd20,  48, 0, 0,  0);   // heal 20 from 36, saturates
    issue(1'b0, 9'd12,  36, 0, 10, 0);   // start during DRAW ignored
    issue(1'b1, 9'd20,  48, 0, 0,  0);
    issue(1'b0, 9'd12,  36, 0, 0,  30);  // reset mid-draw
    issue(1'b0, 9'd12,  36, 0, 0,  0);   // clean repeat after abort
    issue(1'b0, 9'd0,   36, 0, 0,  0);   // damage 0, no draw
    issue(1'b0, 9'd26,  10, 0, 0,  0);
    issue(1'b0, 9'd100, 0,  1, 0,  0);   // overkill, game over
    issue(1'b1, 9'd5,   0,  1, 0,  0);   // heal blocked after game over

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
